// File: rtl/sys_array_os.sv
// sys_array_os: output-stationary ROWS x COLS signed MAC array. A/B beats
// are skewed per lane, swept through the PEs, flushed, then drained one
// result row at a time.
// Ports: clk, rst (async active-low); start/k_len job control;
// in_valid/in_ready/a_data/b_data beat input; out_valid/out_ready/
// out_data/out_row result rows; busy; done (one-cycle pulse).
// Option macro SYS_ARRAY_OS_RELU_EN: clamp negative drained values to 0.
// Requires ROWS >= 2 and COLS >= 2.
module sys_array_os #(
  parameter int DW   = 16,
  parameter int ACCW = 40,
  parameter int ROWS = 4,
  parameter int COLS = 4,
  parameter int KW   = 16,
  parameter int RW   = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [KW-1:0]        k_len,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [ROWS*DW-1:0]   a_data,
  input  logic [COLS*DW-1:0]   b_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [COLS*ACCW-1:0] out_data,
  output logic [RW-1:0]        out_row,
  output logic                 busy,
  output logic                 done
);
  localparam int FW = $clog2(ROWS + COLS);

  typedef enum logic [2:0] {
    S_IDLE, S_COMPUTE, S_FLUSH, S_DRAIN, S_DONE
  } state_t;

  state_t               state_q, state_d;
  logic [KW-1:0]        k_q, k_d;
  logic [KW-1:0]        cnt_q, cnt_d;
  logic [FW-1:0]        fl_q, fl_d;
  logic                 ov_q, ov_d;
  logic [COLS*ACCW-1:0] od_q, od_d;
  logic [RW-1:0]        orow_q, orow_d;
  logic                 done_q, done_d;
  logic                 xfer, clr, ld;
  logic [RW-1:0]        rsel;

  assign in_ready = (state_q == S_COMPUTE);
  assign xfer     = in_valid && in_ready;
  assign busy     = (state_q != S_IDLE);
  assign out_valid = ov_q;
  assign out_data  = od_q;
  assign out_row   = orow_q;
  assign done      = done_q;

  // Skew: lane i enters the array i cycles late, carrying its valid bit.
  logic signed [DW-1:0] a_sk [ROWS];
  logic                 a_skv [ROWS];
  logic signed [DW-1:0] b_sk [COLS];
  logic                 b_skv [COLS];

  for (genvar gi = 0; gi < ROWS; gi++) begin : g_ask
    if (gi == 0) begin : g_0
      assign a_sk[gi]  = a_data[DW-1:0];
      assign a_skv[gi] = xfer;
    end else begin : g_n
      logic [DW-1:0] d_q [gi];
      logic          v_q [gi];
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          for (int s = 0; s < gi; s++) begin
            d_q[s] <= '0;
            v_q[s] <= 1'b0;
          end
        end else begin
          d_q[0] <= a_data[gi*DW +: DW];
          v_q[0] <= xfer;
          for (int s = 1; s < gi; s++) begin
            d_q[s] <= d_q[s-1];
            v_q[s] <= v_q[s-1];
          end
        end
      end
      assign a_sk[gi]  = d_q[gi-1];
      assign a_skv[gi] = v_q[gi-1];
    end
  end

  for (genvar gj = 0; gj < COLS; gj++) begin : g_bsk
    if (gj == 0) begin : g_0
      assign b_sk[gj]  = b_data[DW-1:0];
      assign b_skv[gj] = xfer;
    end else begin : g_n
      logic [DW-1:0] d_q [gj];
      logic          v_q [gj];
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          for (int s = 0; s < gj; s++) begin
            d_q[s] <= '0;
            v_q[s] <= 1'b0;
          end
        end else begin
          d_q[0] <= b_data[gj*DW +: DW];
          v_q[0] <= xfer;
          for (int s = 1; s < gj; s++) begin
            d_q[s] <= d_q[s-1];
            v_q[s] <= v_q[s-1];
          end
        end
      end
      assign b_sk[gj]  = d_q[gj-1];
      assign b_skv[gj] = v_q[gj-1];
    end
  end

  // PE operand links: A moves right, B moves down, one register per hop.
  logic signed [DW-1:0] a_in [ROWS][COLS];
  logic signed [DW-1:0] b_in [ROWS][COLS];
  logic                 av_in [ROWS][COLS];
  logic                 bv_in [ROWS][COLS];
  logic [DW-1:0]        ah_q [ROWS][COLS-1];
  logic                 ahv_q [ROWS][COLS-1];
  logic [DW-1:0]        bh_q [ROWS-1][COLS];
  logic                 bhv_q [ROWS-1][COLS];

  for (genvar gi = 0; gi < ROWS; gi++) begin : g_r
    for (genvar gj = 0; gj < COLS; gj++) begin : g_c
      if (gj == 0) begin : g_al
        assign a_in[gi][gj]  = a_sk[gi];
        assign av_in[gi][gj] = a_skv[gi];
      end else begin : g_ai
        assign a_in[gi][gj]  = ah_q[gi][gj-1];
        assign av_in[gi][gj] = ahv_q[gi][gj-1];
      end
      if (gi == 0) begin : g_bt
        assign b_in[gi][gj]  = b_sk[gj];
        assign bv_in[gi][gj] = b_skv[gj];
      end else begin : g_bi
        assign b_in[gi][gj]  = bh_q[gi-1][gj];
        assign bv_in[gi][gj] = bhv_q[gi-1][gj];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < ROWS; i++)
        for (int j = 0; j < COLS-1; j++) begin
          ah_q[i][j]  <= '0;
          ahv_q[i][j] <= 1'b0;
        end
      for (int i = 0; i < ROWS-1; i++)
        for (int j = 0; j < COLS; j++) begin
          bh_q[i][j]  <= '0;
          bhv_q[i][j] <= 1'b0;
        end
    end else begin
      for (int i = 0; i < ROWS; i++)
        for (int j = 0; j < COLS-1; j++) begin
          ah_q[i][j]  <= a_in[i][j];
          ahv_q[i][j] <= av_in[i][j];
        end
      for (int i = 0; i < ROWS-1; i++)
        for (int j = 0; j < COLS; j++) begin
          bh_q[i][j]  <= b_in[i][j];
          bhv_q[i][j] <= bv_in[i][j];
        end
    end
  end

  logic signed [2*DW-1:0] prod  [ROWS][COLS];
  logic signed [ACCW-1:0] acc_q [ROWS][COLS];
  logic signed [ACCW-1:0] acc_d [ROWS][COLS];

  always_comb begin
    for (int i = 0; i < ROWS; i++)
      for (int j = 0; j < COLS; j++) begin
        prod[i][j] = (2*DW)'(a_in[i][j]) * (2*DW)'(b_in[i][j]);
        if (clr)
          acc_d[i][j] = '0;
        else if (av_in[i][j] && bv_in[i][j])
          acc_d[i][j] = acc_q[i][j] + ACCW'(prod[i][j]);
        else
          acc_d[i][j] = acc_q[i][j];
      end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < ROWS; i++)
        for (int j = 0; j < COLS; j++)
          acc_q[i][j] <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  function automatic logic [ACCW-1:0] post(input logic signed [ACCW-1:0] v);
`ifdef SYS_ARRAY_OS_RELU_EN
    post = v[ACCW-1] ? '0 : v;
`else
    post = v;
`endif
  endfunction

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    cnt_d   = cnt_q;
    fl_d    = fl_q;
    ov_d    = ov_q;
    od_d    = od_q;
    orow_d  = orow_q;
    done_d  = 1'b0;
    clr     = 1'b0;
    ld      = 1'b0;
    rsel    = orow_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          k_d   = k_len;
          cnt_d = '0;
          fl_d  = '0;
          clr   = 1'b1;
          state_d = (k_len == '0) ? S_FLUSH : S_COMPUTE;
        end
      end
      S_COMPUTE: begin
        if (xfer) begin
          cnt_d = cnt_q + KW'(1);
          if (cnt_q == k_q - KW'(1))
            state_d = S_FLUSH;
        end
      end
      S_FLUSH: begin
        fl_d = fl_q + FW'(1);
        // last skewed beat reaches PE(ROWS-1,COLS-1) before this edge
        if (fl_q == FW'(ROWS + COLS - 2))
          state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (!ov_q) begin
          ov_d = 1'b1;
          ld   = 1'b1;
        end else if (out_ready) begin
          if (orow_q == RW'(ROWS - 1)) begin
            ov_d    = 1'b0;
            od_d    = '0;
            orow_d  = '0;
            done_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            orow_d = orow_q + RW'(1);
            rsel   = orow_q + RW'(1);
            ld     = 1'b1;
          end
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (ld) begin
      for (int j = 0; j < COLS; j++)
        od_d[j*ACCW +: ACCW] = post(acc_q[rsel][j]);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      cnt_q   <= '0;
      fl_q    <= '0;
      ov_q    <= 1'b0;
      od_q    <= '0;
      orow_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      cnt_q   <= cnt_d;
      fl_q    <= fl_d;
      ov_q    <= ov_d;
      od_q    <= od_d;
      orow_q  <= orow_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_sys_array_os.sv
// tb_sys_array_os: scoreboard bench for sys_array_os (4x4, DW=8, ACCW=32).
// Expected rows come from a plain matrix-multiply model.
module tb_sys_array_os;
  localparam int DW = 8;
  localparam int ACCW = 32;
  localparam int ROWS = 4;
  localparam int COLS = 4;
  localparam int KW = 16;
  localparam int KMAX = 16;

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic                 start = 1'b0;
  logic [KW-1:0]        k_len = '0;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic [ROWS*DW-1:0]   a_data = '0;
  logic [COLS*DW-1:0]   b_data = '0;
  logic                 out_valid;
  logic                 out_ready = 1'b1;
  logic [COLS*ACCW-1:0] out_data;
  logic [1:0]           out_row;
  logic                 busy;
  logic                 done;

  always #5 clk = ~clk;

  sys_array_os #(
    .DW(DW), .ACCW(ACCW), .ROWS(ROWS), .COLS(COLS), .KW(KW)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .k_len(k_len),
    .in_valid(in_valid), .in_ready(in_ready),
    .a_data(a_data), .b_data(b_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_row(out_row),
    .busy(busy), .done(done)
  );

  typedef struct packed {
    logic [1:0]           row;
    logic [COLS*ACCW-1:0] data;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;

  logic signed [DW-1:0] am [ROWS][KMAX];
  logic signed [DW-1:0] bm [KMAX][COLS];

  task automatic run_job(input string nm, input int k, input int gap,
                         input int stall_row, input int stall_n);
    logic signed [ACCW-1:0] s;
    exp_t e;
    int got, ndone, edges, lat, cyc;
    bit stalled;
    logic [COLS*ACCW-1:0] held;
    logic [1:0] held_r;
    for (int r = 0; r < ROWS; r++) begin
      e.row = 2'(r);
      e.data = '0;
      for (int c = 0; c < COLS; c++) begin
        s = '0;
        for (int kk = 0; kk < k; kk++)
          s += ACCW'(am[r][kk]) * ACCW'(bm[kk][c]);
`ifdef SYS_ARRAY_OS_RELU_EN
        if (s < 0) s = '0;
`endif
        e.data[c*ACCW +: ACCW] = s;
      end
      exp_q.push_back(e);
    end
    @(negedge clk);
    start = 1'b1;
    k_len = KW'(k);
    @(negedge clk);
    start = 1'b0;
    for (int b = 0; b < k; b++) begin
      for (int i = 0; i < ROWS; i++) a_data[i*DW +: DW] = am[i][b];
      for (int j = 0; j < COLS; j++) b_data[j*DW +: DW] = bm[b][j];
      in_valid = 1'b1;
      cyc = 0;
      while (!in_ready && cyc < 50) begin
        @(negedge clk);
        cyc++;
      end
      checks++;
      if (in_ready !== 1'b1) begin
        errors++;
        $display("FAIL %s in_ready beat %0d: got %b want 1", nm, b, in_ready);
      end
      @(negedge clk);
      in_valid = 1'b0;
      a_data = ROWS*DW'($urandom);
      b_data = COLS*DW'($urandom);
      if (b < k - 1) repeat (gap) @(negedge clk);
    end
    edges = 0; lat = -1; got = 0; ndone = 0; stalled = 0; cyc = 0;
    while (cyc < 400 && !(got == ROWS && !busy)) begin
      @(negedge clk);
      cyc++; edges++;
      if (done) ndone++;
      if (out_valid && lat < 0) lat = edges;
      if (out_valid) begin
        if (!stalled && stall_n > 0 && out_row == 2'(stall_row)) begin
          stalled = 1;
          held = out_data;
          held_r = out_row;
          out_ready = 1'b0;
          repeat (stall_n) begin
            @(negedge clk);
            cyc++; edges++;
            if (done) ndone++;
            checks++;
            if (out_data !== held || out_row !== held_r || out_valid !== 1'b1) begin
              errors++;
              $display("FAIL %s stall_hold: got row %0d v %b data %h want row %0d v 1 data %h",
                       nm, out_row, out_valid, out_data, held_r, held);
            end
          end
          out_ready = 1'b1;
        end
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL %s extra_row: got row %0d want none", nm, out_row);
        end else begin
          e = exp_q.pop_front();
          if (out_row !== e.row || out_data !== e.data) begin
            errors++;
            $display("FAIL %s row: got row %0d data %h want row %0d data %h",
                     nm, out_row, out_data, e.row, e.data);
          end
        end
        got++;
      end
    end
    if (k > 0) begin
      checks++;
      if (lat != ROWS + COLS) begin
        errors++;
        $display("FAIL %s latency: got %0d want %0d", nm, lat, ROWS + COLS);
      end
    end
    checks++;
    if (got != ROWS) begin
      errors++;
      $display("FAIL %s rows_delivered: got %0d want %0d", nm, got, ROWS);
    end
    checks++;
    if (ndone != 1) begin
      errors++;
      $display("FAIL %s done_pulses: got %0d want 1", nm, ndone);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s leftover_rows: got %0d want 0", nm, exp_q.size());
      exp_q.delete();
    end
    checks++;
    if ({busy, out_valid, done, out_row, out_data} !== '0) begin
      errors++;
      $display("FAIL %s idle_outputs: got busy %b v %b done %b row %0d data %h want all 0",
               nm, busy, out_valid, done, out_row, out_data);
    end
  endtask

  task automatic fill_const(input int k, input int av, input int bv);
    for (int kk = 0; kk < k; kk++) begin
      for (int i = 0; i < ROWS; i++) am[i][kk] = DW'(av);
      for (int j = 0; j < COLS; j++) bm[kk][j] = DW'(bv);
    end
  endtask

  task automatic fill_rand(input int k);
    for (int kk = 0; kk < k; kk++) begin
      for (int i = 0; i < ROWS; i++) am[i][kk] = DW'($urandom);
      for (int j = 0; j < COLS; j++) bm[kk][j] = DW'($urandom);
    end
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, in_ready, out_valid, done, out_row, out_data} !== '0) begin
      errors++;
      $display("FAIL reset_held: got busy %b rdy %b v %b done %b row %0d data %h want 0",
               busy, in_ready, out_valid, done, out_row, out_data);
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, in_ready, out_valid, done, out_row, out_data} !== '0) begin
      errors++;
      $display("FAIL reset_released: got busy %b rdy %b v %b done %b row %0d data %h want 0",
               busy, in_ready, out_valid, done, out_row, out_data);
    end
  endtask

  task automatic test_basic;
    for (int i = 0; i < ROWS; i++) am[i][0] = DW'(i + 1);
    for (int j = 0; j < COLS; j++) bm[0][j] = DW'(1);
    run_job("basic_k1", 1, 0, 0, 0);
  endtask

  task automatic test_gap;
    fill_rand(3);
    run_job("k3_nogap", 3, 0, 0, 0);
    run_job("k3_gap2", 3, 2, 0, 0);
  endtask

  task automatic test_backpressure;
    fill_rand(2);
    run_job("stall_row1", 2, 0, 1, 5);
  endtask

  task automatic test_extreme;
    fill_const(4, -128, -128);
    run_job("min_operands", 4, 0, 0, 0);
  endtask

  task automatic test_k_zero;
    fill_rand(2);
    run_job("k0_zero_rows", 0, 0, 0, 0);
  endtask

  task automatic test_reset_mid;
    bit bad;
    @(negedge clk);
    start = 1'b1;
    k_len = KW'(3);
    @(negedge clk);
    start = 1'b0;
    a_data = 32'h05050505;
    b_data = 32'h07070707;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({busy, in_ready, out_valid, done, out_row, out_data} !== '0) begin
      errors++;
      $display("FAIL mid_reset_outputs: got busy %b rdy %b v %b done %b row %0d data %h want 0",
               busy, in_ready, out_valid, done, out_row, out_data);
    end
    @(negedge clk);
    rst = 1'b1;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (out_valid || busy || done) bad = 1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL mid_reset_quiet: got activity 1 want 0");
    end
    fill_const(1, 2, 3);
    run_job("after_reset", 1, 0, 0, 0);
  endtask

  task automatic test_relu;
    fill_const(1, -1, 5);
    run_job("neg_result", 1, 0, 0, 0);
  endtask

  initial begin
    test_reset;
    test_basic;
    test_gap;
    test_backpressure;
    test_extreme;
    test_k_zero;
    test_reset_mid;
    test_relu;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
